// File: rtl/regfile_pkg.sv
// Shared types and defaults for the integer register file and its scoreboard.
package regfile_pkg;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;

    typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0]           reg_data_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy vector for in-flight register writes, with set-over-clear priority and popcount.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                setEn,
    input  logic [ADDR_W-1:0]   setReg,
    input  logic                clrEn,
    input  logic [ADDR_W-1:0]   clrReg,
    output logic [NUM_REGS-1:0] busy,
    output logic [ADDR_W:0]     pendingCnt
);

    logic [NUM_REGS-1:0] busyNext;

    // A new producer supersedes the retiring one, so set is applied after clear.
    always_comb begin
        busyNext = busy;
        if (clrEn)
            busyNext[clrReg] = 1'b0;
        if (setEn)
            busyNext[setReg] = 1'b1;
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            busy <= '0;
        else
            busy <= busyNext;
    end

    always_comb begin
        pendingCnt = '0;
        for (int i = 0; i < NUM_REGS; i++)
            pendingCnt = pendingCnt + {{ADDR_W{1'b0}}, busy[i]};
    end

endmodule

// File: rtl/banco_registros_sb.sv
// Parametrised integer register file with optional write bypass and in-flight write scoreboard.
module banco_registros_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       RegWrite,
    input  logic [ADDR_W-1:0]          writeReg,
    input  logic [DATA_W-1:0]          writeData,
    input  logic [NUM_RD*ADDR_W-1:0]   readReg,
    output logic [NUM_RD*DATA_W-1:0]   readData,
    input  logic                       issue_en,
    input  logic [ADDR_W-1:0]          issue_rd,
    output logic [NUM_RD-1:0]          hazard,
    output logic [NUM_REGS-1:0]        busy,
    output logic [ADDR_W:0]            pending_cnt
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wrActive;

    assign wrActive = RegWrite && (writeReg != '0);

    // Entry 0 is only ever written by reset, so it always holds zero.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wrActive) begin
            regs[writeReg] <= writeData;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) uScoreboard (
        .CLK        (CLK),
        .RESET      (RESET),
        .setEn      (issue_en),
        .setReg     (issue_rd),
        .clrEn      (RegWrite),
        .clrReg     (writeReg),
        .busy       (busy),
        .pendingCnt (pending_cnt)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : gRead
        logic [ADDR_W-1:0] rdAddr;
        logic              addrMatch;
        logic              fwd;

        assign rdAddr    = readReg[k*ADDR_W +: ADDR_W];
        assign addrMatch = (BYPASS != 0) && RegWrite && (writeReg == rdAddr);
        assign fwd       = addrMatch && !RESET && (rdAddr != '0);

        assign readData[k*DATA_W +: DATA_W] = (rdAddr == '0) ? '0 :
                                              fwd            ? writeData :
                                                               regs[rdAddr];
        // busy[0] is never set, so register 0 cannot raise a hazard.
        assign hazard[k] = busy[rdAddr] && !addrMatch;
    end

endmodule

// File: doc/banco_registros_sb.md
# banco_registros_sb

Parametrised integer register file for the pipelined core, successor to the fixed 32×32 two-read-port bank. It adds a configurable number of read ports, synchronous reset of all architectural registers, optional write-to-read bypass, and a per-register scoreboard that tracks in-flight writes and flags read hazards to the decode/stall logic. It sits between decode (read/issue) and writeback (write/retire).

## Interface

Parameters:
- `DATA_W`, default 32: register width in bits.
- `NUM_REGS`, default 32: architectural register count; power of two, ≥2. Local `ADDR_W = $clog2(NUM_REGS)`.
- `NUM_RD`, default 2: read port count, 1–4.
- `BYPASS`, default 1: 1 forwards same-cycle write data to matching reads; 0 returns stored value only.

Ports. One clock; reset is synchronous and active-high.
- `CLK`, in, 1: clock; all state updates on the rising edge.
- `RESET`, in, 1: synchronous, active-high.
- `RegWrite`, in, 1: writeback enable.
- `writeReg`, in, `ADDR_W`: writeback destination.
- `writeData`, in, `DATA_W`: writeback data.
- `readReg`, in, `NUM_RD*ADDR_W`: read addresses; port k occupies bits `[k*ADDR_W +: ADDR_W]`.
- `readData`, out, `NUM_RD*DATA_W`: read data, packed the same way.
- `issue_en`, in, 1: instruction with destination issued this cycle.
- `issue_rd`, in, `ADDR_W`: destination of the issued instruction.
- `hazard`, out, `NUM_RD`: bit k is 1 when port k reads a register with an unresolved pending write.
- `busy`, out, `NUM_REGS`: scoreboard vector.
- `pending_cnt`, out, `ADDR_W+1`: number of set `busy` bits.

## Operation

- **Register 0:**
  - Reads as 0 on every port.
  - Writes to it are discarded.
  - Issues to it never set `busy[0]`.
  - `busy[0]` is constantly 0.
- **Write:** on an edge with `RegWrite=1`, `writeReg≠0` and `RESET=0`, the register is updated to `writeData`.
- **Read:** combinational, per port.
  - With `BYPASS=1`, `RegWrite=1`, `writeReg==readReg[k]≠0` and `RESET=0`, `readData[k]=writeData`.
  - Otherwise `readData[k]` is the stored value.
- **Scoreboard:**
  - An edge with `issue_en=1` and `issue_rd≠0` sets `busy[issue_rd]`.
  - An edge with `RegWrite=1` and `writeReg≠0` clears `busy[writeReg]`.
  - Same register set and cleared on the same edge: set wins, because the new producer supersedes the retiring one.
  - Issue to an already-busy register keeps it busy; there is no nesting count, since the core issues in order.
- **Hazard:** `hazard[k] = busy[readReg[k]] && !(BYPASS && RegWrite && writeReg==readReg[k])`. It is always 0 for register 0.
- **pending_cnt:** combinational popcount of `busy`.
- **Reset:**
  - Any edge with `RESET=1` clears every register and every `busy` bit.
  - Writes and issues on that edge are ignored.
  - Bypass is suppressed while `RESET=1`.
- **Reset values, first edge after RESET:** `readData` all 0, `hazard`=0, `busy`=0, `pending_cnt`=0.

## Timing

- Write latency:
  - Data is visible through storage the cycle after the write edge.
  - With `BYPASS=1` it is visible in the same cycle.
- Scoreboard: `busy` and `hazard` reflect an issue the cycle after `issue_en`.
- `hazard` is combinational from `readReg`, `RegWrite` and `writeReg` plus registered `busy`. Decode samples it in the same cycle.
- Reset mid-operation: pending writes are lost, and a writeback arriving after reset only clears an already-clear bit.
- No handshake back-pressure: the block always accepts writes and issues.

## Structure

- Shared package `regfile_pkg`:
  - defaults for `DATA_W` and `NUM_REGS`
  - `reg_addr_t`
  - `reg_data_t`
  - constant `REG_ZERO = '0`
- One sub-module `regfile_scoreboard`: holds the busy vector, the set/clear priority logic and the popcount. It is instantiated once.
- Storage and the read muxes stay in the top module, with one `generate` loop over `NUM_RD`.

## Test plan

- **Reset:** load x5=0xDEADBEEF, assert `RESET` for 1 cycle → all reads 0, `busy`=0, `pending_cnt`=0.
- **Write and read:** write x7=0x12345678.
  - Next cycle, port 0 reading x7 → 0x12345678.
  - Write x0=0xFFFFFFFF → reads of x0 return 0.
- **Bypass:** same-cycle write x3=0xA5A5A5A5 while port 1 reads x3.
  - `BYPASS=1` → 0xA5A5A5A5.
  - `BYPASS=0` → old value.
- **Scoreboard:**
  - Issue rd=9 → next cycle `busy[9]=1`, `hazard[0]=1` for a read of x9, `pending_cnt=1`.
  - Writeback x9 → `hazard` drops in that cycle (`BYPASS=1`) and `busy[9]=0` after the edge.
- **Simultaneous events:** issue rd=4 and writeback x4 on the same edge → `busy[4]` stays 1. Issue rd=0 → `busy` unchanged.
- **Parametrisation:** rerun with `NUM_REGS=16`, `NUM_RD=3`, `DATA_W=64`.
  - Write x15 → all three ports read it back.
  - 15 issues → `pending_cnt=15`.
